// File: rtl/uart_pkg.sv
// uart_pkg: receive-path state encoding and parameter legality checks.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } uart_rx_state_t;
`endif

   localparam int MIN_DIV = 4;

   function automatic bit data_bits_ok(input int n);
      return (n >= 5) && (n <= 9);
   endfunction

   function automatic bit stop_bits_ok(input int n);
      return (n == 1) || (n == 2);
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: control/strobe bundle between a frame FSM and its
// bit-period counter (master = FSM side, slave = counter side).
interface uart_rx_frame_if;
   import uart_pkg::*;

   logic run;
   logic load_half;
   logic load_full;
   logic tick;

   modport master (
      output run,
      output load_half,
      output load_full,
      input  tick
   );

   modport slave (
      input  run,
      input  load_half,
      input  load_full,
      output tick
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter; a half period after load_half,
// then one tick every DIV cycles while run is high.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int DIV  = 86,
   parameter int HALF = 43
) (
   input  logic iCLK,
   input  logic iRESETn,
   uart_rx_frame_if.slave bus
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LIM_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] LIM_HALF = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          half_q, half_d;
   logic          hit;

   assign hit      = bus.run && (cnt_q == (half_q ? LIM_HALF : LIM_FULL));
   assign bus.tick = hit;

   // Next count: loads win, a tick wraps to a full period, else count.
   always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      if (bus.load_half) begin
         cnt_d  = '0;
         half_d = 1'b1;
      end else if (bus.load_full) begin
         cnt_d  = '0;
         half_d = 1'b0;
      end else if (hit) begin
         cnt_d  = '0;
         half_d = 1'b0;
      end else if (bus.run) begin
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // Counter state register.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         cnt_q  <= '0;
         half_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver with start validation and error strobes.
// Optional feature macro: UART_RX_PARITY_EN (parity bit and oPARITY_ERR).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 10_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                 iCLK,
   input  logic                 iRESETn,
   input  logic                 iUART_RX,
   input  logic                 iPARITY_ODD,
   output logic [DATA_BITS-1:0] oRX_DATA,
   output logic                 oRX_VALID,
   output logic                 oFRAME_ERR,
   output logic                 oPARITY_ERR,
   output logic                 oRX_BUSY,
   output logic                 oRX_TICK
);

   localparam int DIV  = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int IW   = $clog2(DATA_BITS);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   if (DIV < MIN_DIV) begin : g_bad_div
      $error("uart_rx_frame: CLOCK_FREQ/BAUD_RATE must be >= 4");
   end
   if (!data_bits_ok(DATA_BITS)) begin : g_bad_db
      $error("uart_rx_frame: DATA_BITS must be 5..9");
   end
   if (!stop_bits_ok(STOP_BITS)) begin : g_bad_sb
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
   end

   uart_rx_state_t       state_q, state_d;
   logic [1:0]           sync_q;
   logic                 prev_q;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 stop_bad_q, stop_bad_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;
   logic                 start_edge;
   logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 perr_o_q, perr_o_d;
`else
   logic                 unused_parity_odd;
   assign unused_parity_odd = iPARITY_ODD;
`endif

   uart_rx_frame_if bif ();

   uart_baud_cnt #(
      .DIV  (DIV),
      .HALF (HALF)
   ) u_baud (
      .iCLK    (iCLK),
      .iRESETn (iRESETn),
      .bus     (bif.slave)
   );

   assign rx_s       = sync_q[1];
   assign start_edge = prev_q & ~rx_s;
   assign stop_bad   = stop_bad_q | ~rx_s;

   // Two-flop synchroniser plus the previous value for edge detection.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], iUART_RX};
         prev_q <= sync_q[1];
      end
   end

   // Frame FSM: next state, counter control, shift and strobes.
   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      data_d        = data_q;
      idx_d         = idx_q;
      stop_idx_d    = stop_idx_q;
      stop_bad_d    = stop_bad_q;
      valid_d       = 1'b0;
      ferr_d        = 1'b0;
      bif.run       = (state_q != IDLE);
      bif.load_half = 1'b0;
      bif.load_full = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d        = perr_q;
      perr_o_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d       = START;
               bif.load_half = 1'b1;
               idx_d         = '0;
               stop_idx_d    = 1'b0;
               stop_bad_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d        = 1'b0;
`endif
            end
         end
         START: begin
            if (bif.tick) begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d       = DATA;
                  idx_d         = '0;
                  bif.load_full = 1'b1;
               end
            end
         end
         DATA: begin
            if (bif.tick) begin
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bif.tick) begin
               perr_d  = ((^shreg_q) ^ rx_s) != iPARITY_ODD;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bif.tick) begin
               if (stop_idx_q == STOP_LAST) begin
                  state_d = IDLE;
                  if (stop_bad) begin
                     ferr_d = 1'b1;
                  end else begin
                     valid_d  = 1'b1;
                     data_d   = shreg_q;
`ifdef UART_RX_PARITY_EN
                     perr_o_d = perr_q;
`endif
                  end
               end else begin
                  stop_idx_d = 1'b1;
                  stop_bad_d = stop_bad;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame state, datapath and registered strobes.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         data_q     <= '0;
         idx_q      <= '0;
         stop_idx_q <= 1'b0;
         stop_bad_q <= 1'b0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         idx_q      <= idx_d;
         stop_idx_q <= stop_idx_d;
         stop_bad_q <= stop_bad_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Latched parity result and its output strobe.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         perr_q   <= 1'b0;
         perr_o_q <= 1'b0;
      end else begin
         perr_q   <= perr_d;
         perr_o_q <= perr_o_d;
      end
   end
   assign oPARITY_ERR = perr_o_q;
`else
   assign oPARITY_ERR = 1'b0;
`endif

   assign oRX_DATA   = data_q;
   assign oRX_VALID  = valid_q;
   assign oFRAME_ERR = ferr_q;
   assign oRX_BUSY   = (state_q != IDLE);
   assign oRX_TICK   = bif.tick;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames for uart_rx_frame at DIV=86, HALF=43.
// Honours UART_RX_PARITY_EN when the RTL is built with it.
module tb_uart_rx_frame;

   localparam int DIV = 86;
`ifdef UART_RX_PARITY_EN
   localparam int LAT   = 906;
   localparam int NTICK = 11;
   localparam int NPERR = 1;
`else
   localparam int LAT   = 820;
   localparam int NTICK = 10;
   localparam int NPERR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       par_odd = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, perr, busy, tick;
`ifdef UART_RX_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   uart_rx_frame_if mon ();
   assign mon.run       = busy;
   assign mon.tick      = tick;
   assign mon.load_half = 1'b0;
   assign mon.load_full = 1'b0;
   wire unused_mon = mon.load_half | mon.load_full;

   uart_rx_frame #(
      .CLOCK_FREQ (10_000_000),
      .BAUD_RATE  (115_200),
      .DATA_BITS  (8),
      .STOP_BITS  (1)
   ) dut (
      .iCLK        (clk),
      .iRESETn     (rst_n),
      .iUART_RX    (rx),
      .iPARITY_ODD (par_odd),
      .oRX_DATA    (data),
      .oRX_VALID   (valid),
      .oFRAME_ERR  (ferr),
      .oPARITY_ERR (perr),
      .oRX_BUSY    (busy),
      .oRX_TICK    (tick)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         valid_n = 0, ferr_n = 0, perr_n = 0;
   int         tick_n = 0, perr_tot = 0, ev_cyc = 0;
   int         fall_cyc = 0;
   logic [7:0] hist [4];

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            if (valid_n < 4) hist[valid_n] = data;
            valid_n++;
            ev_cyc = cyc;
         end
         if (ferr) begin
            ferr_n++;
            ev_cyc = cyc;
         end
         if (perr && valid) perr_n++;
         if (perr) perr_tot++;
         if (mon.tick) tick_n++;
      end
   end

   int n_pass = 0, n_tot = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic clr();
      valid_n = 0;
      ferr_n  = 0;
      perr_n  = 0;
      tick_n  = 0;
      ev_cyc  = 0;
      for (int i = 0; i < 4; i++) hist[i] = 8'hxx;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      fall_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_odd ^ par_flip);
`endif
      send_bit(stop);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vt [6];

   initial begin
      vt[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
      vt[1] = '{8'hA3, 1'b1, 1, 0, 8'hA3};
      vt[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vt[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vt[4] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
      vt[5] = '{8'h0F, 1'b1, 1, 0, 8'h0F};

      repeat (3) @(negedge clk);
      chk("rst_data", int'(data), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_ferr", int'(ferr), 0);
      chk("rst_perr", int'(perr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tick", int'(tick), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", int'(mon.run), 0);

      for (int k = 0; k < 6; k++) begin
         clr();
         send_frame(vt[k].d, vt[k].stop);
         rx = 1'b1;
         repeat (DIV) @(negedge clk);
         chk($sformatf("v%0d_valid", k), valid_n, vt[k].exp_valid);
         chk($sformatf("v%0d_ferr", k), ferr_n, vt[k].exp_ferr);
         chk($sformatf("v%0d_perr", k), perr_n, 0);
         chk($sformatf("v%0d_data", k), int'(data), int'(vt[k].exp_data));
         chk($sformatf("v%0d_ticks", k), tick_n, NTICK);
         chk($sformatf("v%0d_lat", k), ev_cyc - fall_cyc, LAT);
         chk($sformatf("v%0d_busy", k), int'(busy), 0);
      end

      clr();
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
      chk("b2b_valid", valid_n, 2);
      chk("b2b_d0", int'(hist[0]), 8'hA3);
      chk("b2b_d1", int'(hist[1]), 8'h0F);
      chk("b2b_ticks", tick_n, 2 * NTICK);
      chk("b2b_ferr", ferr_n, 0);

      clr();
      fall_cyc = cyc;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_busy_c38", int'(mon.run), 1);
      repeat (6) @(negedge clk);
      chk("glitch_busy_c44", int'(mon.run), 0);
      repeat (2 * DIV) @(negedge clk);
      chk("glitch_ticks", tick_n, 1);
      chk("glitch_valid", valid_n, 0);
      chk("glitch_ferr", ferr_n, 0);

      clr();
      send_frame(8'h3C, 1'b0);
      repeat (30 * DIV) @(negedge clk);
      chk("brk_ferr", ferr_n, 1);
      chk("brk_valid", valid_n, 0);
      chk("brk_ticks", tick_n, NTICK);
      chk("brk_data", int'(data), 8'h0F);
      chk("brk_busy", int'(busy), 0);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);

      clr();
      fall_cyc = cyc;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      rx = 1'b0;
      repeat (DIV / 2) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_data", int'(data), 0);
      chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_ferr", int'(ferr), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_tick", int'(tick), 0);
      rst_n = 1'b1;
      repeat (12 * DIV) @(negedge clk);
      chk("mid_after_valid", valid_n, 0);
      chk("mid_after_ferr", ferr_n, 0);
      chk("mid_after_busy", int'(busy), 0);
      clr();
      send_frame(8'h81, 1'b1);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
      chk("rec_valid", valid_n, 1);
      chk("rec_data", int'(hist[0]), 8'h81);

`ifdef UART_RX_PARITY_EN
      clr();
      par_odd  = 1'b0;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
      chk("par_valid", valid_n, 1);
      chk("par_perr", perr_n, 1);
      chk("par_lat", ev_cyc - fall_cyc, 906);
      chk("par_data", int'(hist[0]), 8'h07);
      clr();
      par_odd  = 1'b1;
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
      chk("par_odd_valid", valid_n, 1);
      chk("par_odd_perr", perr_n, 0);
`endif
      chk("perr_total", perr_tot, NPERR);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
